// File: rtl/marie_mem_responder.sv
// ---------------------------------------------------------------------------
// marie_mem_responder
//
// Word-addressed memory slave for a MARIE-style CPU bus using a 4-phase
// req/ack handshake. A request is sampled in IDLE when req and cs are both
// high. The responder then inserts WAIT_CYCLES wait states, performs the
// access, and raises ack. The ack stays high until the CPU drops req.
// ack rises exactly 1+WAIT_CYCLES rising edges after the sampling edge.
// Addresses at or above DEPTH complete with err=1 and rdata=0. They never
// touch the array.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   cs     in   chip select; qualifies req
//   req    in   request, held high until ack is seen
//   we     in   1=write, 0=read (sampled with req)
//   addr   in   word address, ADDR_WIDTH bits (sampled with req)
//   wdata  in   write data, DATA_WIDTH bits (sampled with req)
//   rdata  out  registered read data; holds until next read or error
//   ack    out  registered completion acknowledge
//   err    out  registered out-of-range flag, meaningful while ack=1
// ---------------------------------------------------------------------------
module marie_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
    // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;

    // Request capture registers; deliberately not reset (pure datapath).
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_access;
    logic                    w_in_range;
    logic                    w_mem_we;
    logic [MEM_AW-1:0]       w_idx;

    assign w_accept   = (r_state == ST_IDLE) && req && cs;
    // The access happens on the edge that leaves WAIT with the counter already at zero.
    // That edge is the one that raises ack, which gives the 1+WAIT_CYCLES latency.
    assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    // The full address is compared, so out-of-range addresses never alias into the array.
    assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx      = r_addr[MEM_AW-1:0];
    assign w_mem_we   = w_access && r_we && w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= WAIT_L;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_access) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        if (w_in_range) begin
                            r_err <= 1'b0;
                            if (!r_we) begin
                                r_rdata <= r_mem[w_idx];
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    // Leaving only on req=0 guarantees one access per 4-phase handshake.
                    if (!req) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the request only on the accepting edge. Later bus changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Array has no reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;

endmodule

// File: tb/tb_marie_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_marie_mem_responder
//
// Directed bench for marie_mem_responder. dut1 runs with WAIT_CYCLES=1.
// dut3 runs with WAIT_CYCLES=3. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_marie_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        cs1 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [11:0] addr1 = '0;
    logic [15:0] wdata1 = '0;
    logic [15:0] rdata1;
    logic        ack1, err1;

    logic        cs3 = 1'b0, req3 = 1'b0, we3 = 1'b0;
    logic [11:0] addr3 = '0;
    logic [15:0] wdata3 = '0;
    logic [15:0] rdata3;
    logic        ack3, err3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    marie_mem_responder #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(512), .WAIT_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs1), .req(req1), .we(we1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ack(ack1), .err(err1)
    );

    marie_mem_responder #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(512), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .cs(cs3), .req(req3), .we(we3),
        .addr(addr3), .wdata(wdata3), .rdata(rdata3), .ack(ack3), .err(err3)
    );

    // Runs one full handshake on the selected instance and reports what was seen.
    // lat is the number of edges from the sampling edge to ack (-1 if no ack).
    task automatic xfer(input int sel, input logic w, input logic [11:0] a,
                        input logic [15:0] d, output int lat, output logic e,
                        output logic [15:0] rd, output logic ack_after);
        logic a_now;
        @(negedge clk);
        if (sel == 1) begin
            cs1 = 1'b1; req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            cs3 = 1'b1; req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d;
        end
        lat = -1; e = 1'bx; rd = 'x;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            a_now = (sel == 1) ? ack1 : ack3;
            if (a_now === 1'b1) begin
                lat = n;
                e   = (sel == 1) ? err1 : err3;
                rd  = (sel == 1) ? rdata1 : rdata3;
                break;
            end
        end
        @(negedge clk);
        if (sel == 1) req1 = 1'b0; else req3 = 1'b0;
        @(posedge clk); #1;
        ack_after = (sel == 1) ? ack1 : ack3;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack1, err1, rdata1} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: ack=%b err=%b rdata=%h want 0 0 0000", ack1, err1, rdata1);
        end
        n_cmp++;
        if ({ack3, err3, rdata3} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_dut3: ack=%b err=%b rdata=%h want 0 0 0000", ack3, err3, rdata3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic e; logic [15:0] rd; logic aa;
        xfer(1, 1'b1, 12'h100, 16'h110C, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || rd !== 16'h0000 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL wr100: lat=%0d err=%b rdata=%h ackoff=%b want 2 0 0000 0", lat, e, rd, aa);
        end
        xfer(1, 1'b0, 12'h100, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || rd !== 16'h110C || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL rd100: lat=%0d err=%b rdata=%h ackoff=%b want 2 0 110c 0", lat, e, rd, aa);
        end
        xfer(1, 1'b1, 12'h000, 16'hA5A5, lat, e, rd, aa);
        xfer(1, 1'b1, 12'h1FF, 16'h5A5A, lat, e, rd, aa);
        xfer(1, 1'b0, 12'h1FF, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || rd !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL rd1ff: lat=%0d err=%b rdata=%h want 2 0 5a5a", lat, e, rd);
        end
    endtask

    task automatic test_wait3();
        int lat; logic e; logic [15:0] rd; logic aa;
        xfer(3, 1'b1, 12'h10B, 16'h0005, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 4 || e !== 1'b0 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL w3_wr10b: lat=%0d err=%b ackoff=%b want 4 0 0", lat, e, aa);
        end
        xfer(3, 1'b0, 12'h10B, 16'hFFFF, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 4 || e !== 1'b0 || rd !== 16'h0005) begin
            n_fail++;
            $display("FAIL w3_rd10b: lat=%0d err=%b rdata=%h want 4 0 0005", lat, e, rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic e; logic [15:0] rd; logic aa;
        // 0x300 and 0xFFF would alias onto 0x100 and 0x1FF if the address wrapped.
        xfer(1, 1'b1, 12'h300, 16'hFFFF, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || e !== 1'b1 || rd !== 16'h0000 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_wr300: lat=%0d err=%b rdata=%h ackoff=%b want 2 1 0000 0", lat, e, rd, aa);
        end
        n_cmp++;
        if (err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_errclr: err=%b want 0", err1);
        end
        xfer(1, 1'b1, 12'hFFF, 16'hFFFF, lat, e, rd, aa);
        xfer(1, 1'b0, 12'h200, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || e !== 1'b1 || rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor_rd200: lat=%0d err=%b rdata=%h want 2 1 0000", lat, e, rd);
        end
        xfer(1, 1'b0, 12'h100, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (e !== 1'b0 || rd !== 16'h110C) begin
            n_fail++;
            $display("FAIL oor_keep100: err=%b rdata=%h want 0 110c", e, rd);
        end
        xfer(1, 1'b0, 12'h000, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (rd !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL oor_keep000: rdata=%h want a5a5", rd);
        end
        xfer(1, 1'b0, 12'h1FF, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (rd !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL oor_keep1ff: rdata=%h want 5a5a", rd);
        end
    endtask

    task automatic test_hold();
        int lat; logic e; logic [15:0] rd; logic aa;
        int found;
        xfer(1, 1'b1, 12'h10D, 16'h0000, lat, e, rd, aa);
        @(negedge clk);
        cs1 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 12'h10C; wdata1 = 16'h0007;
        @(posedge clk); #1;
        // Sampling edge has passed; the bus now changes but must not affect the access.
        we1 = 1'b0; addr1 = 12'h10D; wdata1 = 16'hDEAD;
        found = -1;
        for (int n = 1; n < 20; n++) begin
            @(posedge clk); #1;
            if (ack1 === 1'b1) begin found = n; break; end
        end
        n_cmp++;
        if (found !== 2) begin
            n_fail++;
            $display("FAIL hold_lat: lat=%0d want 2", found);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack1 !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_ack%0d: ack=%b want 1", k, ack1);
            end
        end
        @(negedge clk) req1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drop: ack=%b want 0", ack1);
        end
        xfer(1, 1'b0, 12'h10C, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || rd !== 16'h0007) begin
            n_fail++;
            $display("FAIL hold_rd10c: lat=%0d rdata=%h want 2 0007", lat, rd);
        end
        xfer(1, 1'b0, 12'h10D, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL hold_rd10d: rdata=%h want 0000", rd);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic e; logic [15:0] rd; logic aa;
        int seen;
        // Load rdata with a non-zero value so the reset clear is visible.
        xfer(1, 1'b0, 12'h100, 16'h0000, lat, e, rd, aa);
        @(negedge clk);
        cs1 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 12'h10D; wdata1 = 16'h1234;
        @(posedge clk);   // sampling edge
        @(posedge clk);   // counter reaches zero, access is due on the next edge
        @(negedge clk) rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ack1 !== 1'b0 || rdata1 !== 16'h0000 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: ack=%b err=%b rdata=%h want 0 0 0000", ack1, err1, rdata1);
        end
        req1 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack1 !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_noack: ack high on %0d edges want 0", seen);
        end
        xfer(1, 1'b0, 12'h10D, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || rd !== 16'h0000 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rd10d: lat=%0d err=%b rdata=%h want 2 0 0000", lat, e, rd);
        end
    endtask

    task automatic test_cs_low();
        int lat; logic e; logic [15:0] rd; logic aa;
        int seen;
        xfer(1, 1'b0, 12'h100, 16'h0000, lat, e, rd, aa);
        @(negedge clk);
        cs1 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 12'h100; wdata1 = 16'h9999;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ack1 !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL cs0_noack: ack high on %0d edges want 0", seen);
        end
        n_cmp++;
        if (rdata1 !== 16'h110C) begin
            n_fail++;
            $display("FAIL cs0_rdata: rdata=%h want 110c", rdata1);
        end
        @(negedge clk) req1 = 1'b0;
        xfer(1, 1'b0, 12'h100, 16'h0000, lat, e, rd, aa);
        n_cmp++;
        if (lat !== 2 || rd !== 16'h110C) begin
            n_fail++;
            $display("FAIL cs0_mem: lat=%0d rdata=%h want 2 110c", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait3();
        test_out_of_range();
        test_hold();
        test_reset_abort();
        test_cs_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
